// File: rtl/alu_rr_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_rr_sched_if
// Description : Bundles the signals of the two-port ALU round-robin
//               scheduler into one interface.
//               - Requester 0 and 1: valid/ready handshake plus A, B and
//                 opcode payload.
//               - Shared ALU: operand and select outputs, result and carry
//                 inputs.
//               - Response channel: valid/ready plus id, y and carry.
//               - busy status.
//               Modport 'slave' is the scheduler side. Modport 'master' is
//               the client/ALU side.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_rr_sched_if #(
    parameter int WIDTH = 8,
    parameter int OP_W  = 3
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [OP_W-1:0]  req0_op;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [OP_W-1:0]  req1_op;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [OP_W-1:0]  alu_s;
    logic [WIDTH-1:0] alu_y;
    logic             alu_carry;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_y;
    logic             rsp_carry;

    logic             busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req1_ready,
        output alu_a, alu_b, alu_s,
        input  alu_y, alu_carry,
        output rsp_valid, rsp_id, rsp_y, rsp_carry,
        input  rsp_ready,
        output busy
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req1_ready,
        input  alu_a, alu_b, alu_s,
        output alu_y, alu_carry,
        input  rsp_valid, rsp_id, rsp_y, rsp_carry,
        output rsp_ready,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/alu_rr_sched.sv
`default_nettype none
// ============================================================================
// Module      : alu_rr_sched
// Description : Round-robin scheduler sharing one external 8-bit
//               combinational ALU between two requesters.
//               - One operation is in flight at a time: IDLE -> EXEC -> RESP.
//               - The operands are registered on acceptance and drive the
//                 ALU.
//               - The ALU result is captured at the end of EXEC and returned
//                 on the response channel, tagged with the requester id.
// Ports       : clk   - clock, rising edge
//               rst_n - asynchronous active-low reset
//               bus   - alu_rr_sched_if.slave (request, ALU and response
//                       signals)
// Revision    : 1.0 - initial release
// ============================================================================
module alu_rr_sched #(
    parameter int WIDTH = 8,
    parameter int OP_W  = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_rr_sched_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic             r_last_grant;
    logic             r_id;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [OP_W-1:0]  r_op;

    logic             r_rsp_id;
    logic [WIDTH-1:0] r_rsp_y;
    logic             r_rsp_carry;

    logic             w_grant;
    logic             w_rdy0;
    logic             w_rdy1;
    logic             w_accept;

    // Arbitration: a lone requester wins. On a tie, the port that was not
    // served last wins.
    always_comb begin
        w_grant = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            w_grant = ~r_last_grant;
        end else if (bus.req1_valid) begin
            w_grant = 1'b1;
        end
    end

    // Each ready is gated with rst_n, so both read 0 throughout reset even
    // though the state register already shows IDLE.
    assign w_rdy0   = rst_n && (r_state == IDLE) && bus.req0_valid && !w_grant;
    assign w_rdy1   = rst_n && (r_state == IDLE) && bus.req1_valid &&  w_grant;
    assign w_accept = w_rdy0 || w_rdy1;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept)      w_state_nxt = EXEC;
            EXEC:                       w_state_nxt = RESP;
            RESP:    if (bus.rsp_ready) w_state_nxt = IDLE;
            default:                    w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The operand registers change only on acceptance, so the ALU inputs
    // hold steady outside EXEC whatever the requesters present.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
            r_id         <= 1'b0;
            r_a          <= '0;
            r_b          <= '0;
            r_op         <= '0;
        end else if (w_accept) begin
            r_last_grant <= w_grant;
            r_id         <= w_grant;
            r_a          <= w_grant ? bus.req1_a  : bus.req0_a;
            r_b          <= w_grant ? bus.req1_b  : bus.req0_b;
            r_op         <= w_grant ? bus.req1_op : bus.req0_op;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_id    <= 1'b0;
            r_rsp_y     <= '0;
            r_rsp_carry <= 1'b0;
        end else if (r_state == EXEC) begin
            r_rsp_id    <= r_id;
            r_rsp_y     <= bus.alu_y;
            r_rsp_carry <= bus.alu_carry;
        end
    end

    assign bus.req0_ready = w_rdy0;
    assign bus.req1_ready = w_rdy1;
    assign bus.alu_a      = r_a;
    assign bus.alu_b      = r_b;
    assign bus.alu_s      = r_op;
    assign bus.rsp_valid  = (r_state == RESP);
    assign bus.rsp_id     = r_rsp_id;
    assign bus.rsp_y      = r_rsp_y;
    assign bus.rsp_carry  = r_rsp_carry;
    assign bus.busy       = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_rr_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_rr_sched
// Description : Testbench for alu_rr_sched.
//               - Provides the external ALU.
//               - Drives directed and random requester traffic.
//               - Compares the DUT against a reference model of the
//                 arbitration, latency and result rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_rr_sched;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_rr_sched_if #(.WIDTH(8), .OP_W(3)) bus ();

    alu_rr_sched #(.WIDTH(8), .OP_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Accepted grants and the cycles at which they were accepted.
    int g_order[$];
    int g_cyc[$];

    // Reference ALU result as {carry, y}.
    function automatic logic [8:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                           input logic [2:0] op);
        case (op)
            3'd0:    ref_alu = {1'b0, a} + {1'b0, b};
            3'd1:    ref_alu = {1'b0, a} - {1'b0, b};
            3'd2:    ref_alu = {1'b0, a & b};
            3'd3:    ref_alu = {1'b0, a | b};
            3'd4:    ref_alu = {1'b0, a ^ b};
            3'd5:    ref_alu = {1'b0, ~a};
            3'd6:    ref_alu = {1'b0, a << 1};
            default: ref_alu = {1'b0, a >> 1};
        endcase
    endfunction

    // External combinational ALU.
    assign {bus.alu_carry, bus.alu_y} = ref_alu(bus.alu_a, bus.alu_b, bus.alu_s);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req0_valid = 1'b0; bus.req0_a = 8'h00; bus.req0_b = 8'h00; bus.req0_op = 3'd0;
        bus.req1_valid = 1'b0; bus.req1_a = 8'h00; bus.req1_b = 8'h00; bus.req1_op = 3'd0;
        bus.rsp_ready  = 1'b0;
    endtask

    task automatic pulse_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        logic [32:0] obs;
        clear_inputs();
        rst_n = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #2;
        n_checks++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_ready: got %b want 00", {bus.req0_ready, bus.req1_ready});
        end
        obs = {bus.busy, bus.rsp_valid, bus.rsp_id, bus.rsp_y, bus.rsp_carry,
               bus.alu_a, bus.alu_b, bus.alu_s};
        n_checks++;
        if (obs !== 33'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0", obs);
        end
        clear_inputs();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // One operation on one port with fixed expected result and fixed timing.
    // Starts and ends idle at posedge+1.
    task automatic test_single_op(input bit port, input logic [7:0] a, input logic [7:0] b,
                                  input logic [2:0] op, input logic [7:0] exp_y,
                                  input logic exp_c, input string name);
        if (!port) begin
            bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
        end
        #1;
        n_checks++;
        if ({bus.req0_ready, bus.req1_ready} !== (port ? 2'b01 : 2'b10)) begin
            n_fail++;
            $display("FAIL %s_ready: got %b want %b", name,
                     {bus.req0_ready, bus.req1_ready}, (port ? 2'b01 : 2'b10));
        end
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        #1;
        n_checks++;
        if ({bus.busy, bus.rsp_valid, bus.alu_a, bus.alu_b, bus.alu_s} !== {2'b10, a, b, op}) begin
            n_fail++;
            $display("FAIL %s_exec: got %h want %h", name,
                     {bus.busy, bus.rsp_valid, bus.alu_a, bus.alu_b, bus.alu_s},
                     {2'b10, a, b, op});
        end
        tick();
        n_checks++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_y, bus.rsp_carry} !== {1'b1, port, exp_y, exp_c}) begin
            n_fail++;
            $display("FAIL %s_rsp: got v=%b id=%b y=%h c=%b want v=1 id=%b y=%h c=%b", name,
                     bus.rsp_valid, bus.rsp_id, bus.rsp_y, bus.rsp_carry, port, exp_y, exp_c);
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        #1;
        n_checks++;
        if ({bus.busy, bus.rsp_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL %s_done: got busy/valid %b want 00", name, {bus.busy, bus.rsp_valid});
        end
    endtask

    // Cycle-by-cycle traffic engine checked against the reference model.
    // Model phase: 0 = waiting for a request, 1 = operands on the ALU,
    // 2 = response offered.
    task automatic run_traffic(input int n0, input int n1, input bit rnd,
                               input bit start_last, input string name);
        int         rem[2];
        bit         pend[2];
        logic [7:0] pa[2];
        logic [7:0] pb[2];
        logic [2:0] po[2];
        int         phase;
        bit         last;
        bit         g;
        bit         done;
        logic [7:0] ea, eb, ey;
        logic [2:0] eop;
        logic       ec, eid;
        logic [8:0] r;
        rem[0] = n0; rem[1] = n1;
        pend[0] = 1'b0; pend[1] = 1'b0;
        pa[0] = 8'h00; pa[1] = 8'h00; pb[0] = 8'h00; pb[1] = 8'h00; po[0] = 3'd0; po[1] = 3'd0;
        phase = 0; last = start_last; done = 1'b0;
        ea = 8'h00; eb = 8'h00; ey = 8'h00; eop = 3'd0; ec = 1'b0; eid = 1'b0;
        g_order.delete();
        g_cyc.delete();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (rem[0] == 0 && rem[1] == 0 && phase == 0) begin
                done = 1'b1;
                break;
            end
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && rem[p] > 0 && (!rnd || $urandom_range(0, 1) == 1)) begin
                    pend[p] = 1'b1;
                    pa[p] = 8'($urandom);
                    pb[p] = 8'($urandom);
                    po[p] = 3'($urandom);
                end
            end
            bus.req0_valid = pend[0]; bus.req0_a = pa[0]; bus.req0_b = pb[0]; bus.req0_op = po[0];
            bus.req1_valid = pend[1]; bus.req1_a = pa[1]; bus.req1_b = pb[1]; bus.req1_op = po[1];
            bus.rsp_ready  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            case (phase)
                0: begin
                    if (pend[0] && pend[1]) g = ~last;
                    else                    g = pend[1];
                    n_checks++;
                    if ({bus.req0_ready, bus.req1_ready, bus.busy, bus.rsp_valid} !==
                        {pend[0] && !g, pend[1] && g, 2'b00}) begin
                        n_fail++;
                        $display("FAIL %s_idle c%0d: got rdy/busy/valid %b want %b", name, cyc,
                                 {bus.req0_ready, bus.req1_ready, bus.busy, bus.rsp_valid},
                                 {pend[0] && !g, pend[1] && g, 2'b00});
                    end
                    if (pend[0] || pend[1]) begin
                        ea = pa[g]; eb = pb[g]; eop = po[g]; eid = g;
                        r = ref_alu(ea, eb, eop);
                        ey = r[7:0]; ec = r[8];
                        last = g;
                        pend[g] = 1'b0;
                        rem[g]--;
                        g_order.push_back(int'(g));
                        g_cyc.push_back(cyc);
                        phase = 1;
                    end
                end
                1: begin
                    n_checks++;
                    if ({bus.req0_ready, bus.req1_ready, bus.busy, bus.rsp_valid,
                         bus.alu_a, bus.alu_b, bus.alu_s} !== {4'b0010, ea, eb, eop}) begin
                        n_fail++;
                        $display("FAIL %s_exec c%0d: got %h want %h", name, cyc,
                                 {bus.req0_ready, bus.req1_ready, bus.busy, bus.rsp_valid,
                                  bus.alu_a, bus.alu_b, bus.alu_s}, {4'b0010, ea, eb, eop});
                    end
                    phase = 2;
                end
                default: begin
                    n_checks++;
                    if ({bus.req0_ready, bus.req1_ready, bus.busy, bus.rsp_valid,
                         bus.rsp_id, bus.rsp_y, bus.rsp_carry} !== {4'b0011, eid, ey, ec}) begin
                        n_fail++;
                        $display("FAIL %s_rsp c%0d: got %h want %h", name, cyc,
                                 {bus.req0_ready, bus.req1_ready, bus.busy, bus.rsp_valid,
                                  bus.rsp_id, bus.rsp_y, bus.rsp_carry}, {4'b0011, eid, ey, ec});
                    end
                    if (bus.rsp_ready) phase = 0;
                end
            endcase
            tick();
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s_timeout: got rem0=%0d rem1=%0d phase=%0d want all done",
                     name, rem[0], rem[1], phase);
        end
        clear_inputs();
    endtask

    task automatic test_fairness();
        pulse_reset();
        run_traffic(4, 4, 1'b0, 1'b1, "fair");
        n_checks++;
        if (g_order.size() != 8) begin
            n_fail++;
            $display("FAIL fair_count: got %0d grants want 8", g_order.size());
        end
        for (int i = 0; i < g_order.size(); i++) begin
            n_checks++;
            if (g_order[i] != (i % 2)) begin
                n_fail++;
                $display("FAIL fair_order[%0d]: got %0d want %0d", i, g_order[i], i % 2);
            end
            if (i > 0) begin
                n_checks++;
                if (g_cyc[i] - g_cyc[i-1] != 3) begin
                    n_fail++;
                    $display("FAIL fair_cadence[%0d]: got %0d cycles want 3", i,
                             g_cyc[i] - g_cyc[i-1]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [8:0] r0, r1;
        pulse_reset();
        bus.req0_valid = 1'b1; bus.req0_a = 8'h33; bus.req0_b = 8'h44; bus.req0_op = 3'd0;
        bus.req1_valid = 1'b1; bus.req1_a = 8'h10; bus.req1_b = 8'h20; bus.req1_op = 3'd1;
        r0 = ref_alu(8'h33, 8'h44, 3'd0);
        r1 = ref_alu(8'h10, 8'h20, 3'd1);
        #1;
        n_checks++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL bp_first_grant: got %b want 10", {bus.req0_ready, bus.req1_ready});
        end
        tick();
        // Requester 0 immediately offers another operation.
        bus.req0_a = 8'h99; bus.req0_b = 8'h01; bus.req0_op = 3'd4;
        tick();
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if ({bus.req0_ready, bus.req1_ready, bus.busy, bus.rsp_valid,
                 bus.rsp_id, bus.rsp_y, bus.rsp_carry} !== {4'b0011, 1'b0, r0[7:0], r0[8]}) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got %h want %h", i,
                         {bus.req0_ready, bus.req1_ready, bus.busy, bus.rsp_valid,
                          bus.rsp_id, bus.rsp_y, bus.rsp_carry}, {4'b0011, 1'b0, r0[7:0], r0[8]});
            end
            tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        #1;
        n_checks++;
        if ({bus.req0_ready, bus.req1_ready, bus.rsp_valid} !== 3'b010) begin
            n_fail++;
            $display("FAIL bp_next_grant: got %b want 010",
                     {bus.req0_ready, bus.req1_ready, bus.rsp_valid});
        end
        tick();
        bus.req1_valid = 1'b0;
        tick();
        n_checks++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_y, bus.rsp_carry} !== {2'b11, r1[7:0], r1[8]}) begin
            n_fail++;
            $display("FAIL bp_second_rsp: got %h want %h",
                     {bus.rsp_valid, bus.rsp_id, bus.rsp_y, bus.rsp_carry}, {2'b11, r1[7:0], r1[8]});
        end
        clear_inputs();
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_exec();
        logic [34:0] obs;
        bus.req0_valid = 1'b1; bus.req0_a = 8'hC3; bus.req0_b = 8'h5A; bus.req0_op = 3'd3;
        tick();
        bus.req0_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        obs = {bus.req0_ready, bus.req1_ready, bus.busy, bus.rsp_valid, bus.rsp_id,
               bus.rsp_y, bus.rsp_carry, bus.alu_a, bus.alu_b, bus.alu_s};
        n_checks++;
        if (obs !== 35'd0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got %h want 0", obs);
        end
        tick();
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if ({bus.busy, bus.rsp_valid} !== 2'b00) begin
                n_fail++;
                $display("FAIL midreset_no_rsp[%0d]: got %b want 00", i, {bus.busy, bus.rsp_valid});
            end
        end
        bus.rsp_ready = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        n_checks++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL midreset_tie: got %b want 10", {bus.req0_ready, bus.req1_ready});
        end
        clear_inputs();
        tick();
    endtask

    initial begin
        logic [7:0] sweep_y [6];
        sweep_y = '{8'h24, 8'hBD, 8'h99, 8'h5A, 8'h4A, 8'h52};
        clear_inputs();
        test_reset();
        test_single_op(1'b0, 8'hF0, 8'h20, 3'd0, 8'h10, 1'b1, "req0_add");
        test_single_op(1'b1, 8'h05, 8'h07, 3'd1, 8'hFE, 1'b1, "req1_sub_borrow");
        test_single_op(1'b1, 8'h07, 8'h05, 3'd1, 8'h02, 1'b0, "req1_sub");
        for (int i = 0; i < 6; i++) begin
            test_single_op(1'b0, 8'hA5, 8'h3C, 3'(i + 2), sweep_y[i], 1'b0, "sweep");
        end
        test_fairness();
        test_backpressure();
        pulse_reset();
        run_traffic(20, 20, 1'b1, 1'b1, "random");
        test_reset_mid_exec();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
